gray_conv_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4-bit binary-to-Gray converter among N requesters. Each requester offers a binary word on a valid/ready handshake; the winner's word is converted and held in a single output register with requester ID until the downstream consumer accepts it. The block sits between the requester ports and any Gray-coded consumer, such as a CDC pointer path or a display encoder, so that only one converter instance is needed.

---
 rtl/gray_pkg.sv | 18 +
 rtl/bin2gray_w.sv | 16 +
 rtl/gray_conv_arbiter.sv | 115 +++++++++++
 tb/tb_gray_conv_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-converter arbiter: default width,
// ID-width helper and the output-register state encoding.
package gray_pkg;

  localparam int GRAY_W = 4;

  // Width of a requester index; at least one bit even for degenerate N.
  function automatic int id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Output register occupancy. FULL means out_valid is high.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } gray_state_e;

endpackage

// File: rtl/bin2gray_w.sv
// Parameterised combinational binary-to-Gray converter.
module bin2gray_w
  import gray_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter among N
// requesters, with a single registered output slot.
//
// Handshake: on every port a word moves on a rising edge where valid and
// ready are both high. req_ready is combinational from req_valid, out_ready
// and the registered state; it never depends on req_bin. A requester may
// withdraw req_valid at any time before it is granted.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int W = GRAY_W,
  parameter int N = 4,
  localparam int IDW = id_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [N*W-1:0]    req_bin,
  output logic [N-1:0]      req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_gray,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output gray_state_e       dbg_state
);

  gray_state_e    state_q, state_d;
  logic [IDW-1:0] last_grant;
  logic           can_load;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           xfer;
  logic [W-1:0]   win_bin;
  logic [W-1:0]   win_gray;
  int             idx;

  assign out_valid = (state_q == ST_FULL);
  assign dbg_state = state_q;
  assign can_load  = !out_valid || out_ready;

  // Search from last_grant+1 upward (mod N) for the first valid requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  // A grant is only issued when the slot can take a word and not in reset.
  assign xfer = rst_n && can_load && win_found;

  // One-hot ready for the winner only.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (xfer && (win_id == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Mux the winner's word into the single shared converter.
  always_comb begin
    win_bin = req_bin[win_id*W +: W];
  end

  bin2gray_w #(.W(W)) u_conv (
    .bin  (win_bin),
    .gray (win_gray)
  );

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy: a load always wins over a drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (xfer)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Data, ID and pointer only move on a transfer; drains leave them as-is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_gray   <= '0;
      out_id     <= '0;
      last_grant <= IDW'(N - 1);
    end else if (xfer) begin
      out_gray   <= win_gray;
      out_id     <= win_id;
      last_grant <= win_id;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed bench for gray_conv_arbiter (W=4, N=4).
module tb_gray_conv_arbiter;
  import gray_pkg::*;

  localparam int W = 4;
  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_bin;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [W-1:0]    out_gray;
  logic [1:0]      out_id;
  logic            out_ready;
  gray_state_e     dbg_state;

  int vectors;
  int miscompares;

  gray_conv_arbiter #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    req_bin   = 16'hFFFF;
    step();
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_gray !== 4'b0000 || out_id !== 2'd0 || dbg_state !== ST_EMPTY) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b g=%b id=%0d st=%0d want v=0 g=0000 id=0 st=0",
               out_valid, out_gray, out_id, dbg_state);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_bin        = '0;
    req_bin[7:4]   = 4'b1011;
    req_valid      = 4'b0010;
    out_ready      = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 0010", req_ready);
    end
    step();
    req_valid = '0;
    vectors++;
    if (out_valid !== 1'b1 || out_gray !== 4'b1110 || out_id !== 2'd1) begin
      miscompares++;
      $display("FAIL single_out: got v=%b g=%b id=%0d want v=1 g=1110 id=1",
               out_valid, out_gray, out_id);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gray [4];
    logic [3:0] exp_rdy;
    apply_reset();
    // r0=0101 r1=1111 r2=0011 r3=1000
    req_bin     = {4'b1000, 4'b0011, 4'b1111, 4'b0101};
    exp_gray[0] = 4'b0111;
    exp_gray[1] = 4'b1000;
    exp_gray[2] = 4'b0010;
    exp_gray[3] = 4'b1100;
    req_valid   = 4'b1111;
    out_ready   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = 4'b0001 << (c % 4);
      #1;
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, exp_rdy);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== 2'(c % 4) || out_gray !== exp_gray[c % 4]) begin
        miscompares++;
        $display("FAIL fair_out[%0d]: got v=%b id=%0d g=%b want v=1 id=%0d g=%b",
                 c, out_valid, out_id, out_gray, c % 4, exp_gray[c % 4]);
      end
    end
  endtask

  // Continues from fairness: output holds requester 3 (gray 1100).
  task automatic test_backpressure();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_id !== 2'd3 || out_gray !== 4'b1100) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d g=%b want v=1 id=3 g=1100",
                 c, out_valid, out_id, out_gray);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_resume_ready: got %b want 0001", req_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_gray !== 4'b0111) begin
      miscompares++;
      $display("FAIL bp_resume_out: got v=%b id=%0d g=%b want v=1 id=0 g=0111",
               out_valid, out_id, out_gray);
    end
  endtask

  task automatic test_drain();
    req_valid = '0;
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_gray !== 4'b0111 || out_id !== 2'd0 || dbg_state !== ST_EMPTY) begin
      miscompares++;
      $display("FAIL drain: got v=%b g=%b id=%0d st=%0d want v=0 g=0111 id=0 st=0",
               out_valid, out_gray, out_id, dbg_state);
    end
  endtask

  task automatic test_withdraw();
    bit seen_two;
    seen_two  = 1'b0;
    req_bin   = {4'b1000, 4'b0011, 4'b1111, 4'b0101};
    req_valid = 4'b0010;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL wd_ready[%0d]: got %b want 0000", c, req_ready);
      end
      step();
      if (out_id === 2'd2) seen_two = 1'b1;
    end
    req_valid = '0;
    step();
    if (out_id === 2'd2) seen_two = 1'b1;
    out_ready = 1'b1;
    step();
    if (out_id === 2'd2) seen_two = 1'b1;
    vectors++;
    if (seen_two || out_id !== 2'd1 || out_gray !== 4'b1000 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw: got seen2=%b id=%0d g=%b v=%b want seen2=0 id=1 g=1000 v=0",
               seen_two, out_id, out_gray, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0010;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rstmid_ready: got %b want 0000", req_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rstmid_out: got v=%b id=%0d want v=0 id=0", out_valid, out_id);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rstmid_first_grant: got %b want 0001", req_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_gray !== 4'b0111) begin
      miscompares++;
      $display("FAIL rstmid_first_out: got v=%b id=%0d g=%b want v=1 id=0 g=0111",
               out_valid, out_id, out_gray);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_bin     = '0;
    out_ready   = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_drain();
    test_withdraw();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
